// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, responder state encoding and operation types
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, DONE} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port storage, synchronous write, combinational read
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory slave with wait states, MDR and IR loading
module mem_responder
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] IR,
  output logic              MemReady,
  output logic              Busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, mdr_q, mdr_d, ir_q, ir_d, rdata, rd_val;
  logic irw_q, irw_d, rdy_q, rdy_d, in_range, we;
  assign in_range = 32'(addr_q) < 32'(DEPTH);
  assign rd_val = in_range ? rdata : '0;
  // reset gates the commit so an abort in DONE leaves the array untouched
  assign we = state_q == DONE && op_q == OP_WRITE && in_range && !reset;
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk), .we(we), .addr(addr_q[AW-1:0]), .wdata(wdata_q), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    irw_d = irw_q;
    mdr_d = mdr_q;
    ir_d = ir_q;
    rdy_d = 1'b0;
    case (state_q)
      IDLE: if (MemRead || MemWrite) begin
        state_d = ACCEPT;
        op_d = MemWrite ? OP_WRITE : OP_READ;
        addr_d = Addr;
        wdata_d = WriteData;
        irw_d = IRWrite && !MemWrite;
      end
      ACCEPT: begin
        cnt_d = CW'(WAIT_CYCLES);
        state_d = WAIT_CYCLES == 0 ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q <= CW'(1) ? DONE : WAIT;
      end
      DONE: begin
        state_d = IDLE;
        rdy_d = 1'b1;
        mdr_d = op_q == OP_READ ? rd_val : mdr_q;
        ir_d = op_q == OP_READ && irw_q ? rd_val : ir_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mdr_q <= '0;
      ir_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mdr_q <= mdr_d;
      ir_q <= ir_d;
      rdy_q <= rdy_d;
    end
    op_q <= op_d;
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    irw_q <= irw_d;
  end
  assign MemData = mdr_q;
  assign IR = ir_q;
  assign MemReady = rdy_q;
  assign Busy = state_q != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven scoreboard bench for mem_responder
module tb_mem_responder;
  typedef struct {
    logic rd, wr, irw;
    logic [15:0] addr, wdata, mdr, ir;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
  logic [15:0] Addr = '0, WriteData = '0;
  logic [15:0] MemData, IR;
  logic MemReady, Busy;
  logic MemRead0 = 1'b0;
  logic [15:0] Addr0 = 16'd300, MemData0, IR0;
  logic MemReady0, Busy0;
  int n_chk = 0, n_fail = 0;
  vec_t tbl[12];
  vec_t sb[$];
  always #5 clk = ~clk;
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .Addr(Addr), .WriteData(WriteData), .MemData(MemData), .IR(IR),
    .MemReady(MemReady), .Busy(Busy)
  );
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(MemRead0), .MemWrite(1'b0), .IRWrite(1'b0),
    .Addr(Addr0), .WriteData(16'h0000), .MemData(MemData0), .IR(IR0),
    .MemReady(MemReady0), .Busy(Busy0)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_req(input vec_t v);
    vec_t e;
    int n;
    logic seen;
    @(negedge clk);
    MemRead = v.rd;
    MemWrite = v.wr;
    IRWrite = v.irw;
    Addr = v.addr;
    WriteData = v.wdata;
    sb.push_back(v);
    @(negedge clk);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b1;
    Addr = v.addr ^ 16'h0003;
    WriteData = ~v.wdata;
    chk("busy_after_accept", Busy, 1);
    n = 1;
    seen = MemReady;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = MemReady;
    end
    chk("latency", n - 1, 4);
    e = sb.pop_front();
    chk("mem_data", MemData, e.mdr);
    chk("ir", IR, e.ir);
    IRWrite = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", MemReady, 0);
    chk("mem_data_hold", MemData, e.mdr);
    chk("idle_after_done", Busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    tbl[0]  = '{0, 1, 0, 16'd5,   16'hBEEF, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 0, 0, 16'd5,   16'h0000, 16'hBEEF, 16'h0000};
    tbl[2]  = '{1, 0, 1, 16'd5,   16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[3]  = '{1, 1, 1, 16'd7,   16'h1234, 16'hBEEF, 16'hBEEF};
    tbl[4]  = '{1, 0, 0, 16'd7,   16'h0000, 16'h1234, 16'hBEEF};
    tbl[5]  = '{0, 1, 0, 16'd44,  16'h4444, 16'h1234, 16'hBEEF};
    tbl[6]  = '{1, 0, 0, 16'd300, 16'h0000, 16'h0000, 16'hBEEF};
    tbl[7]  = '{0, 1, 0, 16'd300, 16'hDEAD, 16'h0000, 16'hBEEF};
    tbl[8]  = '{1, 0, 0, 16'd44,  16'h0000, 16'h4444, 16'hBEEF};
    tbl[9]  = '{1, 0, 1, 16'd300, 16'h0000, 16'h0000, 16'h0000};
    tbl[10] = '{0, 1, 0, 16'd9,   16'h0909, 16'h0000, 16'h0000};
    tbl[11] = '{1, 0, 1, 16'd9,   16'h0000, 16'h0909, 16'h0909};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mem_data", MemData, 0);
    chk("reset_ir", IR, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_ready", MemReady, 0);
    foreach (tbl[i]) do_req(tbl[i]);
    @(negedge clk);
    MemWrite = 1'b1;
    Addr = 16'd9;
    WriteData = 16'h5555;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", Busy, 0);
    chk("abort_ready", MemReady, 0);
    chk("abort_mem_data", MemData, 0);
    chk("abort_ir", IR, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= MemReady;
    end
    chk("abort_no_ready", seen, 0);
    do_req('{1, 0, 0, 16'd9, 16'h0000, 16'h0909, 16'h0000});
    @(negedge clk);
    MemRead0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("w0_ready", MemReady0, (i % 3) == 0);
      chk("w0_busy", Busy0, (i % 3) != 0);
    end
    chk("w0_mem_data", MemData0, 0);
    MemRead0 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
